// File: rtl/cube_pkg.sv
// Shared widths, step count and FSM state encodings for the cubing unit.
package cube_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 24;
    localparam int STEPS = 8;
    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SQ   = 2'd1;
    localparam logic [1:0] ST_CB   = 2'd2;

    typedef logic [RES_W-1:0] res_t;
    typedef logic [OP_W-1:0]  op_t;

endpackage

// File: rtl/cube_calc_seq_mul.sv
// Shift-add multiply step unit: one multiplier bit per cycle, LSB first, into a 24-bit accumulator.
module seq_mul
    import cube_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             run,
    input  logic [RES_W-1:0] mcand,
    input  logic [OP_W-1:0]  mplier,
    output logic [RES_W-1:0] acc,
    output logic             done
);

    logic [RES_W-1:0] mcand_q;
    logic [OP_W-1:0]  mplier_q;
    logic [RES_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RES_W-1:0] addend;

    // acc is the value after the step taken on the coming edge, so the caller
    // can reload from it on that same edge without a spare cycle.
    assign addend = mplier_q[0] ? mcand_q : '0;
    assign acc    = acc_q + addend;
    assign done   = run && (cnt_q == CNT_W'(STEPS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (run) begin
            acc_q    <= acc;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/cube_calc.sv
// Sequential cube unit: y = a*a*a using one shared shift-add multiplier in two 8-step phases.
module cube_calc
    import cube_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OP_W-1:0]  a_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic [RES_W-1:0] y_bo,
    output logic [1:0]       dbg_state
);

    // Handshake: start_i is accepted only on an edge where the FSM is IDLE;
    // busy_o rises on that edge and falls on the edge that writes y_bo.
    // start_i seen while busy is dropped, never queued.

    logic [1:0]       state;
    logic [OP_W-1:0]  x;
    logic             mul_load;
    logic             mul_run;
    logic [RES_W-1:0] mul_mcand;
    logic [OP_W-1:0]  mul_mplier;
    logic [RES_W-1:0] mul_acc;
    logic             mul_done;

    assign dbg_state = state;
    assign mul_run   = (state == ST_SQ) || (state == ST_CB);

    always_comb begin
        mul_load   = 1'b0;
        mul_mcand  = '0;
        mul_mplier = '0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    mul_load   = 1'b1;
                    mul_mcand  = {16'b0, a_i};
                    mul_mplier = a_i;
                end
            end
            ST_SQ: begin
                // a*a fits in 16 bits, so only the low half seeds the cube phase.
                if (mul_done) begin
                    mul_load   = 1'b1;
                    mul_mcand  = {8'b0, mul_acc[15:0]};
                    mul_mplier = x;
                end
            end
            default: ;
        endcase
    end

    seq_mul u_mul (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load   (mul_load),
        .run    (mul_run),
        .mcand  (mul_mcand),
        .mplier (mul_mplier),
        .acc    (mul_acc),
        .done   (mul_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            x      <= '0;
            busy_o <= 1'b0;
            y_bo   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        x      <= a_i;
                        y_bo   <= '0;
                        busy_o <= 1'b1;
                        state  <= ST_SQ;
                    end
                end
                ST_SQ: begin
                    if (mul_done) state <= ST_CB;
                end
                ST_CB: begin
                    if (mul_done) begin
                        y_bo   <= mul_acc;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cube_calc.sv
// Directed and randomized bench for cube_calc against an arithmetic cube / cube-root model.
module tb_cube_calc;

    logic        clk_i;
    logic        rst_i;
    logic [7:0]  a_i;
    logic        start_i;
    logic        busy_o;
    logic [23:0] y_bo;
    logic [1:0]  dbg_state;

    int checks;
    int errors;

    cube_calc dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .a_i       (a_i),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .y_bo      (y_bo),
        .dbg_state (dbg_state)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [23:0] model_cube(input int a);
        int unsigned v;
        v = a * a * a;
        return v[23:0];
    endfunction

    function automatic int model_root(input logic [23:0] y);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= int'(y)) r++;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts one operation, optionally pulses start again mid-run, and
    // measures busy length in cycles sampled at negedge.
    task automatic run_one(input logic [7:0] a, input int extra_at, input logic [7:0] extra_a,
                           output int busy_len, output logic [23:0] y_first);
        int n;
        @(negedge clk_i);
        a_i     = a;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        a_i     = $urandom_range(0, 255);
        y_first = y_bo;
        n = 0;
        while (busy_o && n < 40) begin
            n++;
            if (n == extra_at) begin
                a_i     = extra_a;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
        end
        start_i  = 1'b0;
        busy_len = n;
    endtask

    initial begin
        int len;
        int lo;
        logic [23:0] y0;
        logic [7:0] ra;
        checks  = 0;
        errors  = 0;
        rst_i   = 1'b1;
        start_i = 1'b0;
        a_i     = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_busy", 32'(busy_o), 0);
        check("reset_y", 32'(y_bo), 0);
        check("reset_state", 32'(dbg_state), 0);

        run_one(8'd3, 0, 8'd0, len, y0);
        check("a3_busy_len", len, 16);
        check("a3_y_while_busy", 32'(y0), 0);
        check("a3_y", 32'(y_bo), 27);

        run_one(8'd0, 0, 8'd0, len, y0);
        check("a0_y", 32'(y_bo), 0);
        run_one(8'd255, 0, 8'd0, len, y0);
        check("a255_y", 32'(y_bo), 32'hFD02FF);
        check("a255_busy_len", len, 16);

        run_one(8'd5, 6, 8'd9, len, y0);
        check("ignore_busy_len", len, 16);
        check("ignore_y", 32'(y_bo), 125);
        repeat (2) @(negedge clk_i);
        check("ignore_not_queued", 32'(busy_o), 0);

        // start held high: back-to-back runs with one idle cycle between.
        @(negedge clk_i);
        a_i     = 8'd2;
        start_i = 1'b1;
        @(negedge clk_i);
        for (int r = 0; r < 3; r++) begin
            len = 0;
            while (busy_o && len < 40) begin
                len++;
                @(negedge clk_i);
            end
            check("held_busy_len", len, 16);
            check("held_y", 32'(y_bo), 8);
            lo = 0;
            while (!busy_o && lo < 40) begin
                lo++;
                @(negedge clk_i);
            end
            check("held_idle_len", lo, 1);
        end
        start_i = 1'b0;
        len = 0;
        while (busy_o && len < 40) begin
            len++;
            @(negedge clk_i);
        end
        check("held_final_busy_len", len, 16);

        // reset mid-operation
        @(negedge clk_i);
        a_i     = 8'd200;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("pre_reset_busy", 32'(busy_o), 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_busy", 32'(busy_o), 0);
        check("abort_y", 32'(y_bo), 0);
        check("abort_state", 32'(dbg_state), 0);
        run_one(8'd4, 0, 8'd0, len, y0);
        check("after_reset_y", 32'(y_bo), 64);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            run_one(ra, $urandom_range(0, 20), 8'($urandom), len, y0);
            check("rand_busy_len", len, 16);
            check("rand_y", 32'(y_bo), 32'(model_cube(int'(ra))));
        end

        for (int a = 0; a < 256; a++) begin
            run_one(8'(a), 0, 8'd0, len, y0);
            check("sweep_y", 32'(y_bo), 32'(model_cube(a)));
            if (a < 16) check("root_roundtrip", model_root(y_bo), a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
